// File: rtl/perm_unload.sv
// perm_unload: streams a captured 1600-bit Keccak state out as eight 200-bit beats.
// Define PERM_UNLOAD_DOUBLE_BUF_EN to add a pending state slot for gapless back-to-back unloads.
module perm_unload #(
    parameter int CHUNKS = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1599:0] state_in,
    input  logic          state_valid,
    output logic          state_ready,
    output logic [2:0]    doutix,
    output logic [199:0]  dout,
    output logic          pushout,
    output logic          busy,
    output logic          overflow,
    output logic          dbg_state_o
);

    localparam int BEAT_W = 1600 / CHUNKS;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [1599:0]       active_q, active_d;
    logic [BEAT_W-1:0]   dout_q, dout_d;
    logic [2:0]          doutix_q, doutix_d;
    logic                push_q, push_d;
    logic                busy_q, busy_d;
    logic                overflow_q, overflow_d;
    logic                capture;
    logic [2:0]          nxt_ix;

`ifdef PERM_UNLOAD_DOUBLE_BUF_EN
    logic [1599:0]       pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
`endif

    // Handshake: a state transfers at a rising edge where state_valid and state_ready
    // are both high. state_ready depends only on registered state, never on state_valid;
    // an offer made while state_ready is low is dropped and latches the overflow flag.
`ifdef PERM_UNLOAD_DOUBLE_BUF_EN
    assign state_ready = ~pend_vld_q;
`else
    assign state_ready = (state_q == IDLE);
`endif

    assign capture     = state_valid & state_ready;
    assign nxt_ix      = cnt_q + 3'd1;

    assign dout        = dout_q;
    assign doutix      = doutix_q;
    assign pushout     = push_q;
    assign busy        = busy_q;
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        active_d   = active_q;
        dout_d     = dout_q;
        doutix_d   = doutix_q;
        push_d     = 1'b0;
        overflow_d = overflow_q | (state_valid & ~state_ready);
`ifdef PERM_UNLOAD_DOUBLE_BUF_EN
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (capture) begin
                    active_d = state_in;
                    dout_d   = state_in[BEAT_W-1:0];
                    doutix_d = 3'd0;
                    push_d   = 1'b1;
                    cnt_d    = 3'd0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                // cnt_q is the index of the beat currently on dout
                if (cnt_q != 3'd7) begin
                    cnt_d    = nxt_ix;
                    doutix_d = nxt_ix;
                    dout_d   = active_q[BEAT_W*int'(nxt_ix) +: BEAT_W];
                    push_d   = 1'b1;
`ifdef PERM_UNLOAD_DOUBLE_BUF_EN
                    if (capture) begin
                        pend_d     = state_in;
                        pend_vld_d = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = nxt_ix;
`ifdef PERM_UNLOAD_DOUBLE_BUF_EN
                    // A waiting state goes first; state_ready is low while it waits.
                    if (pend_vld_q) begin
                        active_d   = pend_q;
                        pend_vld_d = 1'b0;
                        dout_d     = pend_q[BEAT_W-1:0];
                        doutix_d   = 3'd0;
                        push_d     = 1'b1;
                    end else if (capture) begin
                        active_d = state_in;
                        dout_d   = state_in[BEAT_W-1:0];
                        doutix_d = 3'd0;
                        push_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SEND);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            active_q   <= '0;
            dout_q     <= '0;
            doutix_q   <= 3'd0;
            push_q     <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            dout_q     <= dout_d;
            doutix_q   <= doutix_d;
            push_q     <= push_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef PERM_UNLOAD_DOUBLE_BUF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end
`endif

endmodule

// File: doc/perm_unload.md
PERM_UNLOAD -- requirements
Module: perm_unload

Interface
REQ-001 SHALL have parameter CHUNKS, default 8, meaning the number of 200-bit beats per 1600-bit state; only 8 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port state_in, input, 1600, the permuted Keccak state; lane (x,y) bit z is at bit 64*(5*y+x)+z.
REQ-005 SHALL have port state_valid, input, 1, asserted when state_in holds a state to unload.
REQ-006 SHALL have port state_ready, output, 1, asserted when a state offered this cycle will be captured.
REQ-007 SHALL have port doutix, output, 3, the beat index of dout.
REQ-008 SHALL have port dout, output, 200, the beat data.
REQ-009 SHALL have port pushout, output, 1, asserted for exactly one cycle per valid beat.
REQ-010 SHALL have port busy, output, 1, high while any beat is still to be emitted.
REQ-011 SHALL have port overflow, output, 1, a sticky flag set when state_valid is high while state_ready is low.

Function
REQ-012 SHALL capture state_in into the active register at the rising edge where state_valid and state_ready are both high.
REQ-013 SHALL use FSM states IDLE and SEND: IDLE->SEND on capture; SEND->IDLE after beat 7 unless another state is pending; SEND->SEND otherwise.
REQ-014 SHALL emit beat i as dout = captured[200*i+199:200*i], doutix = i, pushout = 1, for i = 0..7 on 8 consecutive cycles.
REQ-015 SHALL present beat 0 in the cycle after capture; all outputs are registered, giving a latency of 1 cycle.
REQ-016 SHALL hold dout and doutix at their last values with pushout = 0 when not sending.
REQ-017 SHALL use a 3-bit beat counter that wraps 7->0 on the last beat.
REQ-018 SHALL ignore state_valid while state_ready is low: no capture, and overflow set on the next edge.
REQ-019 SHALL keep busy high from the cycle after capture through the cycle presenting the final beat.
REQ-020 SHALL clear overflow only on reset.

Reset
REQ-021 SHALL on reset force FSM = IDLE, counter = 0, dout = 0, doutix = 0, pushout = 0, busy = 0, overflow = 0, all state registers = 0, pending flag = 0.
REQ-022 SHALL abort an unload in progress if reset is asserted mid-unload, emit no further beats, and drop any pending state.
REQ-023 SHALL have state_ready = 1 in the first cycle after reset deassertion.

Configuration
REQ-024 SHALL compile a second 1600-bit pending register and pending flag when macro PERM_UNLOAD_DOUBLE_BUF_EN is defined.
REQ-025 SHALL, with PERM_UNLOAD_DOUBLE_BUF_EN defined, drive state_ready = not pending; a capture during SEND loads the pending register.
REQ-026 SHALL, with PERM_UNLOAD_DOUBLE_BUF_EN defined, transfer pending to active on the beat-7 edge and start the next unload's beat 0 immediately after beat 7, giving an 8-cycle period.
REQ-027 SHALL, with PERM_UNLOAD_DOUBLE_BUF_EN defined and captures arriving back to back, give the state already pending priority; the new state is captured only once the pending slot frees.
REQ-028 SHALL, without PERM_UNLOAD_DOUBLE_BUF_EN, drive state_ready = (FSM == IDLE), giving a minimum 9-cycle period between states.

Verification
REQ-029 SHALL verify single unload: state_in = 1600'h with beat i filled with byte 8'h(i+1), one-cycle valid -> 8 pushouts with doutix 0..7, dout beat i = {25{8'h(i+1)}}, beat 0 one cycle after capture.
REQ-030 SHALL verify lane mapping: only lane (x=1,y=0) bit 0 = 1 -> beat 0 dout = 200'h1 << 64, and all other beats 0.
REQ-031 SHALL verify back-to-back operation: valid held high for states A and B -> with the macro, 16 contiguous pushouts (A then B); without it, 8 beats of A, one idle cycle, then 8 beats of B.
REQ-032 SHALL verify overflow: a third state offered while a state is pending (with the macro) or during SEND (without it) -> state_ready = 0, the state is not emitted, and overflow = 1 and stays 1.
REQ-033 SHALL verify reset mid-unload: reset asserted after beat 3 -> pushout = 0 and busy = 0 immediately, and no beats 4..7 are emitted.
REQ-034 SHALL verify idle outputs: after completion, dout and doutix hold the beat 7 values and pushout = 0 for 20 cycles.
